// File: rtl/render_wireframe.sv
// ============================================================================
// render_wireframe : edge-table wireframe renderer driving a Bresenham line engine
// Option macro: RENDER_WIREFRAME_REJECT_EN (trivial off-screen edge reject)
// Revision: 1.0
// ============================================================================
`default_nettype none

module draw_line #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    done
);
  // Extra headroom so |delta| and 2*err never overflow for any CORDW-bit endpoints
  localparam int DW = CORDW + 4;
  localparam logic signed [CORDW-1:0] ONE = 1;

  logic                    active, neg_x, neg_y;
  logic signed [CORDW-1:0] xe, ye;
  logic signed [DW-1:0]    dx, dy, err, e2, ddx, ddy, adx, ndy;
  logic                    at_end, step_x, step_y;

  always_comb begin
    ddx    = DW'(x1) - DW'(x0);
    ddy    = DW'(y1) - DW'(y0);
    adx    = ddx[DW-1] ? -ddx : ddx;
    ndy    = ddy[DW-1] ? ddy : -ddy;
    e2     = err <<< 1;
    at_end = (x == xe) && (y == ye);
    step_x = (e2 >= dy);
    step_y = (e2 <= dx);
  end

  assign drawing = active && oe;
  assign done    = drawing && at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      neg_x  <= 1'b0;
      neg_y  <= 1'b0;
      x      <= '0;
      y      <= '0;
      xe     <= '0;
      ye     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        x      <= x0;
        y      <= y0;
        xe     <= x1;
        ye     <= y1;
        neg_x  <= ddx[DW-1];
        neg_y  <= ddy[DW-1];
        dx     <= adx;
        dy     <= ndy;
        err    <= adx + ndy;
      end
    end else if (oe) begin
      if (at_end) begin
        active <= 1'b0;
      end else begin
        if (step_x) x <= neg_x ? x - ONE : x + ONE;
        if (step_y) y <= neg_y ? y - ONE : y + ONE;
        err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
      end
    end
  end
endmodule

module render_wireframe #(
  parameter  int CORDW     = 16,
  parameter  int VCORDW    = 9,
  parameter  int CIDXW     = 4,
  parameter  int MAX_EDGES = 16,
  localparam int EW        = $clog2(MAX_EDGES),
  localparam int TW        = 4*VCORDW + CIDXW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tbl_we,
  input  logic [EW-1:0]           tbl_addr,
  input  logic [TW-1:0]           tbl_data,
  input  logic [EW:0]             edge_cnt,
  input  logic [1:0]              scale_sh,
  input  logic signed [CORDW-1:0] off_x,
  input  logic signed [CORDW-1:0] off_y,
  input  logic                    loop,
  input  logic                    start,
  input  logic                    oe,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic [CIDXW-1:0]        cidx,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [2:0] {IDLE, FETCH, XFORM, LAUNCH, DRAW, FDONE} state_t;

  state_t                  state, state_n;
  logic [EW-1:0]           idx, idx_n;
  logic [EW:0]             cnt, cnt_clamp;
  logic [1:0]              sh;
  logic signed [CORDW-1:0] ox, oy;
  logic                    loop_r;
  logic [TW-1:0]           tbl [MAX_EDGES];
  logic [TW-1:0]           ent;
  logic signed [CORDW-1:0] tx0, ty0, tx1, ty1, lx0, ly0, lx1, ly1;
  logic [CIDXW-1:0]        cidx_r;
  logic                    last, reject, draw_start, draw_done;

  function automatic logic [CORDW-1:0] xf(input logic [VCORDW-1:0] v, input logic [1:0] s,
                                          input logic [CORDW-1:0] o);
    return (CORDW'(v) << s) + o;
  endfunction

  assign cnt_clamp = (edge_cnt > (EW+1)'(MAX_EDGES)) ? (EW+1)'(MAX_EDGES) : edge_cnt;
  assign last      = ((EW+1)'(idx) + (EW+1)'(1)) == cnt;

  assign tx0 = xf(ent[4*VCORDW-1 -: VCORDW], sh, ox);
  assign ty0 = xf(ent[3*VCORDW-1 -: VCORDW], sh, oy);
  assign tx1 = xf(ent[2*VCORDW-1 -: VCORDW], sh, ox);
  assign ty1 = xf(ent[VCORDW-1:0],           sh, oy);

`ifdef RENDER_WIREFRAME_REJECT_EN
  localparam logic signed [CORDW-1:0] SCR_W = 320;
  localparam logic signed [CORDW-1:0] SCR_H = 180;
  assign reject = (tx0[CORDW-1] && tx1[CORDW-1]) || (ty0[CORDW-1] && ty1[CORDW-1]) ||
                  (tx0 >= SCR_W && tx1 >= SCR_W) || (ty0 >= SCR_H && ty1 >= SCR_H);
`else
  assign reject = 1'b0;
`endif

  // Table storage has no reset; its contents are meaningless until written
  always_ff @(posedge clk) begin
    if (tbl_we && state == IDLE) tbl[tbl_addr] <= tbl_data;
    if (state == FETCH) ent <= tbl[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      sh     <= '0;
      ox     <= '0;
      oy     <= '0;
      loop_r <= 1'b0;
      cidx_r <= '0;
      lx0    <= '0;
      ly0    <= '0;
      lx1    <= '0;
      ly1    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == IDLE && start) begin
        cnt    <= cnt_clamp;
        sh     <= scale_sh;
        ox     <= off_x;
        oy     <= off_y;
        loop_r <= loop;
      end
      if (state == XFORM) begin
        lx0    <= tx0;
        ly0    <= ty0;
        lx1    <= tx1;
        ly1    <= ty1;
        cidx_r <= ent[TW-1 -: CIDXW];
      end
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    draw_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_n   = '0;
          state_n = (cnt_clamp == '0) ? FDONE : FETCH;
        end
      end
      FETCH: state_n = XFORM;
      XFORM: begin
        if (!reject) begin
          state_n = LAUNCH;
        end else if (last) begin
          state_n = FDONE;
        end else begin
          idx_n   = idx + EW'(1);
          state_n = FETCH;
        end
      end
      LAUNCH: begin
        draw_start = 1'b1;
        state_n    = DRAW;
      end
      DRAW: begin
        if (draw_done) begin
          if (last) begin
            state_n = FDONE;
          end else begin
            idx_n   = idx + EW'(1);
            state_n = FETCH;
          end
        end
      end
      FDONE: begin
        idx_n   = '0;
        state_n = (loop_r && cnt != '0) ? FETCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cidx = cidx_r;
  assign busy = (state != IDLE);
  assign done = (state == FDONE);

  draw_line #(.CORDW(CORDW)) u_line (
    .clk     (clk),
    .rst     (rst),
    .start   (draw_start),
    .oe      (oe),
    .x0      (lx0),
    .y0      (ly0),
    .x1      (lx1),
    .y1      (ly1),
    .x       (x),
    .y       (y),
    .drawing (drawing),
    .done    (draw_done)
  );
endmodule

`default_nettype wire

// File: tb/tb_render_wireframe.sv
// Testbench for render_wireframe: random edge tables against a queue-based pixel model.
`default_nettype none

module tb_render_wireframe;
  localparam int MAX_EDGES = 16;
  localparam int LIMIT     = 20000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tbl_we = 1'b0;
  logic [3:0]         tbl_addr = '0;
  logic [39:0]        tbl_data = '0;
  logic [4:0]         edge_cnt = '0;
  logic [1:0]         scale_sh = '0;
  logic signed [15:0] off_x = '0;
  logic signed [15:0] off_y = '0;
  logic               loop = 1'b0;
  logic               start = 1'b0;
  logic               oe = 1'b1;
  logic signed [15:0] x, y;
  logic [3:0]         cidx;
  logic               drawing, busy, done;

  always #5 clk = ~clk;

  render_wireframe dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .edge_cnt(edge_cnt), .scale_sh(scale_sh), .off_x(off_x), .off_y(off_y), .loop(loop),
    .start(start), .oe(oe), .x(x), .y(y), .cidx(cidx), .drawing(drawing), .busy(busy),
    .done(done)
  );

  int          n_cmp = 0, n_bad = 0, done_cnt = 0, pix_seen = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  int          m_c[MAX_EDGES], m_x0[MAX_EDGES], m_y0[MAX_EDGES], m_x1[MAX_EDGES], m_y1[MAX_EDGES];
  bit          oe_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    oe = oe_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: every presented pixel must be the next one the model predicted
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (drawing) begin
      pix_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pixel_unexpected: got (%0d,%0d,c%0d), required no pixel", x, y, cidx);
      end else begin
        mon_e = exp_q.pop_front();
        if ({x, y, cidx} !== mon_e) begin
          n_bad++;
          $display("FAIL pixel: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)", x, y, cidx,
                   $signed(mon_e[35:20]), $signed(mon_e[19:4]), mon_e[3:0]);
        end
      end
    end
  end

  function automatic int xf(input int v, input int sh, input int off);
    logic signed [15:0] t;
    t = 16'(v << sh) + 16'(off);
    return int'(t);
  endfunction

  task automatic push_line(input int xa, input int ya, input int xb, input int yb, input int c);
    int dx, dy, sx, sy, err, e2;
    dx  = (xb > xa) ? xb - xa : xa - xb;
    dy  = -((yb > ya) ? yb - ya : ya - yb);
    sx  = (xa < xb) ? 1 : -1;
    sy  = (ya < yb) ? 1 : -1;
    err = dx + dy;
    forever begin
      exp_q.push_back({16'(xa), 16'(ya), 4'(c)});
      if (xa == xb && ya == yb) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; xa += sx; end
      if (e2 <= dx) begin err += dx; ya += sy; end
    end
  endtask

  task automatic push_frame(input int cnt, input int sh, input int ox, input int oy);
    int n, a, b, c, d;
    n = (cnt > MAX_EDGES) ? MAX_EDGES : cnt;
    for (int i = 0; i < n; i++) begin
      a = xf(m_x0[i], sh, ox); b = xf(m_y0[i], sh, oy);
      c = xf(m_x1[i], sh, ox); d = xf(m_y1[i], sh, oy);
`ifdef RENDER_WIREFRAME_REJECT_EN
      if ((a < 0 && c < 0) || (b < 0 && d < 0) || (a >= 320 && c >= 320) || (b >= 180 && d >= 180))
        continue;
`endif
      push_line(a, b, c, d, m_c[i]);
    end
  endtask

  task automatic wr(input int a, input int c, input int x0, input int y0, input int x1, input int y1);
    @(posedge clk); #1;
    tbl_we = 1'b1; tbl_addr = 4'(a);
    tbl_data = {4'(c), 9'(x0), 9'(y0), 9'(x1), 9'(y1)};
    m_c[a] = c; m_x0[a] = x0; m_y0[a] = y0; m_x1[a] = x1; m_y1[a] = y1;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic kick(input int cnt, input int sh, input int ox, input int oy, input bit lp);
    @(posedge clk); #1;
    edge_cnt = 5'(cnt); scale_sh = 2'(sh); off_x = 16'(ox); off_y = 16'(oy); loop = lp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (done_cnt < target && t < LIMIT) begin
      @(posedge clk);
      t++;
    end
    check(name, (done_cnt >= target), 1);
  endtask

  task automatic finish_frame(input int d0, input int p0, input int qn, input string name);
    wait_done(d0 + 1, name);
    #1;
    check("busy_after_frame", busy, 0);
    repeat (3) @(posedge clk);
    check("done_count", done_cnt, d0 + 1);
    check("pixel_count", pix_seen - p0, qn);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic frame(input int cnt, input int sh, input int ox, input int oy, input string name);
    int d0, p0, qn;
    push_frame(cnt, sh, ox, oy);
    qn = exp_q.size(); d0 = done_cnt; p0 = pix_seen;
    kick(cnt, sh, ox, oy, 1'b0);
    finish_frame(d0, p0, qn, name);
  endtask

  task automatic reset_check(input string name);
    rst = 1'b1;
    #1;
    check({name, "_x"}, x, 0);
    check({name, "_y"}, y, 0);
    check({name, "_cidx"}, cidx, 0);
    check({name, "_drawing"}, drawing, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, qn;
    #12;
    reset_check("reset");

    // Horizontal line: 11 pixels at y=10
    wr(0, 2, 10, 10, 20, 10);
    p0 = pix_seen;
    frame(1, 0, 0, 0, "hline_timeout");
    check("hline_pixels", pix_seen - p0, 11);

    // Scaled vertical with negative offset: 13 pixels
    wr(0, 5, 0, 0, 0, 3);
    p0 = pix_seen;
    frame(1, 2, -5, 7, "vline_timeout");
    check("vline_pixels", pix_seen - p0, 13);

    // Zero edges: done the cycle after start, nothing drawn
    p0 = pix_seen;
    kick(0, 0, 0, 0, 1'b0);
    check("cnt0_done", done, 1);
    check("cnt0_drawing", drawing, 0);
    @(posedge clk); #1;
    check("cnt0_done_clear", done, 0);
    check("cnt0_idle", busy, 0);
    check("cnt0_pixels", pix_seen - p0, 0);

    // start and table write while busy are both ignored
    wr(0, 3, 0, 0, 40, 0);
    wr(1, 4, 40, 0, 40, 20);
    push_frame(2, 0, 0, 0);
    qn = exp_q.size(); d0 = done_cnt; p0 = pix_seen;
    kick(2, 0, 0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("busy_mid_frame", busy, 1);
    start = 1'b1; tbl_we = 1'b1; tbl_addr = 4'd0; tbl_data = {$urandom(), 8'hA5};
    @(posedge clk); #1;
    start = 1'b0; tbl_we = 1'b0;
    finish_frame(d0, p0, qn, "busy_frame_timeout");
    frame(2, 0, 0, 0, "table_kept_timeout");

    // Random tables, scales and offsets with random output stalls; one clamped count
    oe_rand = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < MAX_EDGES; i++)
        wr(i, $urandom_range(0, 15), $urandom_range(0, 30), $urandom_range(0, 30),
           $urandom_range(0, 30), $urandom_range(0, 30));
      frame((k == 4) ? $urandom_range(17, 31) : $urandom_range(1, 6), $urandom_range(0, 3),
            $urandom_range(0, 300) - 150, $urandom_range(0, 300) - 150, "random_timeout");
    end

    // Cube, looped: two identical frames, then reset ends the loop
    wr(0, 1, 20, 20, 60, 20); wr(1, 2, 60, 20, 60, 60); wr(2, 3, 60, 60, 20, 60);
    wr(3, 4, 20, 60, 20, 20); wr(4, 5, 40, 5, 80, 5);   wr(5, 6, 80, 5, 80, 45);
    wr(6, 7, 80, 45, 60, 60); wr(7, 8, 60, 20, 80, 5);  wr(8, 9, 20, 20, 40, 5);
    push_frame(9, 0, 0, 0);
    push_frame(9, 0, 0, 0);
    d0 = done_cnt;
    kick(9, 0, 0, 0, 1'b1);
    wait_done(d0 + 2, "loop_timeout");
    #1;
    check("loop_restarted", busy, 1);
    check("loop_queue_drained", exp_q.size(), 0);
    reset_check("loop_reset");

    // Reset in the middle of a long edge with stalls, then redraw
    wr(0, 7, 0, 0, 200, 30);
    push_frame(1, 0, 0, 0);
    kick(1, 0, 0, 0, 1'b0);
    repeat (30) @(posedge clk);
    #3;
    check("mid_edge_drawing_started", (exp_q.size() < 201), 1);
    reset_check("mid_reset");
    wr(0, 7, 0, 0, 200, 30);
    frame(1, 0, 0, 0, "redraw_timeout");
    oe_rand = 1'b0;

    // Fully off-screen-left edge, then a straddling edge
    wr(0, 6, 0, 0, 17, 35);
    p0 = pix_seen;
    frame(1, 0, -20, 5, "offscreen_timeout");
`ifdef RENDER_WIREFRAME_REJECT_EN
    check("offscreen_pixels", pix_seen - p0, 0);
`else
    check("offscreen_pixels", pix_seen - p0, 36);
`endif
    wr(0, 8, 0, 0, 6, 0);
    p0 = pix_seen;
    frame(1, 0, -3, 5, "straddle_timeout");
    check("straddle_pixels", pix_seen - p0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
